// File: rtl/word_lane_arbiter.sv
// word_lane_arbiter: round-robin, word-granular arbiter that shares one
// 8->32 bit word packer among NUM_LANES byte streams. A lane keeps its grant
// for exactly four accepted bytes, so a packed word never mixes lanes.
// Optional feature macro: WORD_TIMEOUT_EN (pads a stalled partial word with 0x00).
module word_lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   req_valid,
  input  logic [8*NUM_LANES-1:0] req_data,
  output logic [NUM_LANES-1:0]   req_ready,
  output logic                   valid_in,
  output logic [7:0]             Data_in,
  output logic [LANE_W-1:0]      lane_out,
  output logic                   word_start,
  output logic                   word_end,
  output logic                   busy,
  output logic                   timeout_err
);

  // Reject inconsistent parameter sets at elaboration.
  if (LANE_W != $clog2(NUM_LANES) || TIMEOUT < 1) begin : g_param_check
    $error("word_lane_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {IDLE, GRANT, PAD} state_t;

  state_t              state;
  logic [LANE_W-1:0]   grant;
  logic [LANE_W-1:0]   ptr;
  logic [1:0]          cnt;
  logic [LANE_W-1:0]   base;
  logic [LANE_W-1:0]   pick;
  logic [LANE_W:0]     s;
  logic                found;
  logic                any_req;
  logic                xfer;
  logic [7:0]          byte_sel;

`ifdef WORD_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall;
`endif

  assign any_req  = |req_valid;
  assign xfer     = (state == GRANT) && req_valid[grant];
  assign byte_sel = req_data[{grant, 3'b000} +: 8];
  assign busy     = (state != IDLE);

  // Round-robin pick: first valid lane after base, wrapping; base itself last.
  // From IDLE the search starts after ptr; at a word end it starts after the
  // lane that just finished (ptr is being updated to that lane the same edge).
  always_comb begin
    base  = (state == IDLE) ? ptr : grant;
    pick  = '0;
    found = 1'b0;
    s     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      s = {1'b0, base} + (LANE_W+1)'(i + 1);
      if (s >= (LANE_W+1)'(NUM_LANES)) s = s - (LANE_W+1)'(NUM_LANES);
      if (!found && req_valid[s[LANE_W-1:0]]) begin
        pick  = s[LANE_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Ready goes only to the granted lane and does not wait on its valid.
  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant] = 1'b1;
  end

  // Grant FSM with registered packer-side outputs (one cycle latency).
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= LANE_W'(NUM_LANES - 1);
      cnt         <= '0;
      valid_in    <= 1'b0;
      Data_in     <= '0;
      lane_out    <= '0;
      word_start  <= 1'b0;
      word_end    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef WORD_TIMEOUT_EN
      stall       <= '0;
`endif
    end else begin
      valid_in    <= 1'b0;
      word_start  <= 1'b0;
      word_end    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            valid_in   <= 1'b1;
            Data_in    <= byte_sel;
            lane_out   <= grant;
            word_start <= (cnt == 2'd0);
            word_end   <= (cnt == 2'd3);
            cnt        <= cnt + 2'd1;
`ifdef WORD_TIMEOUT_EN
            stall      <= '0;
`endif
            if (cnt == 2'd3) begin
              ptr <= grant;
              if (any_req) grant <= pick;
              else         state <= IDLE;
            end
          end
`ifdef WORD_TIMEOUT_EN
          // Only a started word can time out; a grant with no bytes waits forever.
          else if (cnt != 2'd0) begin
            if (stall == SW'(TIMEOUT - 1)) begin
              stall <= '0;
              state <= PAD;
            end else begin
              stall <= stall + SW'(1);
            end
          end
`endif
        end
`ifdef WORD_TIMEOUT_EN
        // Fill the rest of the word with zero bytes, then re-arbitrate.
        PAD: begin
          valid_in <= 1'b1;
          Data_in  <= 8'h00;
          lane_out <= grant;
          word_end <= (cnt == 2'd3);
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            timeout_err <= 1'b1;
            ptr         <= grant;
            if (any_req) begin
              grant <= pick;
              state <= GRANT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
